dso_param_meas: RTL
===================

// Module: dso_param_meas
// PURPOSE
//  Gated waveform-parameter measurement on the ADC sample stream, in the ad_clk domain.
//  Per gate window it tracks running max/min and counts rising threshold crossings.
//  The crossing count uses hysteresis.
//  At each gate end it publishes ad_freq/ad_vpp/ad_max/ad_min, which feed the
//  measurement text lines of dso_ui_display.
// PARAMETERS
//  DW           8           ADC sample width (unsigned, 0..2^DW-1 maps -5..+5 V)
//  FREQ_W       20          width of ad_freq; count saturates at 2^FREQ_W-1
//  GATE_CYCLES  50_000_000  gate length in ad_clk cycles; set equal to ad_clk Hz so ad_freq reads in Hz
//  HYST         4           hysteresis half-width in LSBs around the crossing threshold
// PORTS
//  ad_clk     in   1       ADC sample clock; sole clock
//  rst_n      in   1       asynchronous active-low reset
//  ad_valid   in   1       ad_data qualifier; samples with ad_valid=0 are ignored
//  ad_data    in   DW      unsigned ADC sample
//  ad_freq    out  FREQ_W  rising crossings counted in last completed gate
//  ad_vpp     out  DW      ad_max - ad_min of last completed gate
//  ad_max     out  DW      maximum valid sample of last completed gate
//  ad_min     out  DW      minimum valid sample of last completed gate
//  meas_done  out  1       one-cycle pulse when outputs update
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs 0; gate_cnt=0; run_max=0; run_min=2^DW-1; run_cnt=0; seen=0.
//   - thresh=2^(DW-1); schmitt state=LOW.
//  Gate counter:
//   - gate_cnt counts 0..GATE_CYCLES-1 every ad_clk, independent of ad_valid, then wraps to 0.
//   - Cycle gate_cnt==GATE_CYCLES-1 is "gate end" (GE).
//  Accumulate, on each ad_valid=1 cycle:
//   - run_max=max(run_max,ad_data); run_min=min(run_min,ad_data); seen=1.
//  Schmitt crossing detector, on valid samples only:
//   - hi_th=min(thresh+HYST, 2^DW-1); lo_th=max(thresh-HYST, 0), computed in DW+1 bits, then clamped.
//   - LOW->HIGH when ad_data>=hi_th; this transition increments run_cnt, saturating at 2^FREQ_W-1.
//   - HIGH->LOW when ad_data<=lo_th; otherwise the state holds.
//   - Schmitt state is NOT cleared at GE (crossings straddling a gate are counted once).
//  Gate end:
//   - A valid sample on the GE cycle belongs to the ending gate.
//   - Its max/min/crossing effect is included in the published values (forward the
//     updated values into the latch).
//   - On the cycle after GE, outputs register:
//     - ad_max=run_max', ad_min=run_min', ad_vpp=run_max'-run_min', ad_freq=run_cnt'
//       (' = including any GE-cycle sample).
//     - meas_done=1 for exactly that cycle.
//   - If seen'=0, publish ad_max=ad_min=ad_vpp=0, ad_freq=0, and thresh is unchanged.
//   - Otherwise thresh<=(run_max'+run_min')>>1, with the sum in DW+1 bits. The new
//     thresh applies from the first cycle of the next gate.
//   - In the same cycle, accumulators reinit: run_max=0, run_min=2^DW-1, run_cnt=0,
//     seen=0. A valid sample in that cycle starts the new gate normally.
//  Latency: GE cycle -> outputs/meas_done valid 1 cycle later; outputs hold until the next update.
//  Invariants: ad_vpp==ad_max-ad_min always (never negative); ad_min<=ad_max whenever seen.
//  Reset mid-gate discards partial accumulation and restarts the gate from 0.
// TESTING (GATE_CYCLES=1000, HYST=4, DW=8, FREQ_W=20 unless stated)
//  1. Square wave 40/200, period 100 cycles, ad_valid=1:
//     - Gate 1 thresh=128: ad_max=200, ad_min=40, ad_vpp=160, ad_freq=10, meas_done at cycle 1000.
//     - Gate 2: thresh=120, ad_freq=10.
//  2. Constant 128 with +/-3 LSB noise (125..131) after thresh=128 -> ad_freq=0 for every gate.
//  3. ad_valid=0 for a whole gate -> all outputs 0, meas_done still pulses; thresh unchanged.
//  4. Sample 255 only on the GE cycle, others 100:
//     - Publishes ad_max=255, ad_min=100, ad_vpp=155.
//     - Next gate starts with run_max reinit (a 100-only gate then gives ad_max=100).
//  5. FREQ_W=4, 20 crossings per gate -> ad_freq=15 (saturated).
//     thresh=2, HYST=4 -> lo_th clamps to 0, and sample 0 returns the detector to LOW.
//  6. Assert rst_n at gate_cnt=500 mid-square-wave:
//     - All outputs 0 immediately (async).
//     - After release, first meas_done arrives 1000 cycles later with full-gate values.

Source files
------------

// File: rtl/dso_param_meas.sv
// Gated waveform-parameter measurement on the ADC sample stream: per-gate max/min
// and a hysteresis (Schmitt) rising-crossing count, published once per gate.
module dso_param_meas #(
  parameter int DW          = 8,
  parameter int FREQ_W      = 20,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int HYST        = 4
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic              ad_valid,
  input  logic [DW-1:0]     ad_data,
  output logic [FREQ_W-1:0] ad_freq,
  output logic [DW-1:0]     ad_vpp,
  output logic [DW-1:0]     ad_max,
  output logic [DW-1:0]     ad_min,
  output logic              meas_done
);

  localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DW-1:0]   D_MAX     = '1;
  localparam logic [DW:0]     HYST_X    = (DW+1)'(HYST);
  localparam logic [FREQ_W-1:0] F_MAX   = '1;
  localparam logic [DW-1:0]   MID       = DW'(1) << (DW - 1);

  typedef enum logic {SCH_LOW, SCH_HIGH} sch_t;

  logic [GW-1:0]     gate_cnt;
  logic [DW-1:0]     run_max, run_min, thresh;
  logic [FREQ_W-1:0] run_cnt;
  logic              seen;
  sch_t              sch_state;

  logic [DW-1:0]     nxt_max, nxt_min;
  logic [FREQ_W-1:0] nxt_cnt;
  logic              nxt_seen;
  sch_t              sch_nxt;
  logic              gate_end;
  logic [DW:0]       hi_sum, mid_sum;
  logic [DW-1:0]     hi_th, lo_th;

  assign gate_end = (gate_cnt == GATE_LAST);

  // Thresholds are widened by one bit so the +/-HYST window clamps at the rails.
  assign hi_sum  = {1'b0, thresh} + HYST_X;
  assign hi_th   = (hi_sum > {1'b0, D_MAX}) ? D_MAX : hi_sum[DW-1:0];
  assign lo_th   = ({1'b0, thresh} < HYST_X) ? '0 : DW'({1'b0, thresh} - HYST_X);
  assign mid_sum = {1'b0, nxt_max} + {1'b0, nxt_min};

  // Next accumulator/detector values include the current sample, so the gate-end
  // sample is forwarded straight into the published result.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    nxt_max  = run_max;
    nxt_min  = run_min;
    nxt_cnt  = run_cnt;
    nxt_seen = seen;
    sch_nxt  = sch_state;
    if (ad_valid) begin
      nxt_seen = 1'b1;
      if (ad_data > run_max) nxt_max = ad_data;
      if (ad_data < run_min) nxt_min = ad_data;
      case (sch_state)
        SCH_LOW: begin
          if (ad_data >= hi_th) begin
            sch_nxt = SCH_HIGH;
            if (run_cnt != F_MAX) nxt_cnt = run_cnt + 1'b1;
          end
        end
        SCH_HIGH: if (ad_data <= lo_th) sch_nxt = SCH_LOW;
        default:  sch_nxt = SCH_LOW;
      endcase
    end
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      gate_cnt  <= '0;
      run_max   <= '0;
      run_min   <= D_MAX;
      run_cnt   <= '0;
      seen      <= 1'b0;
      thresh    <= MID;
      sch_state <= SCH_LOW;
      ad_freq   <= '0;
      ad_vpp    <= '0;
      ad_max    <= '0;
      ad_min    <= '0;
      meas_done <= 1'b0;
    end else begin
      gate_cnt  <= gate_end ? '0 : gate_cnt + 1'b1;
      sch_state <= sch_nxt;
      meas_done <= gate_end;
      if (gate_end) begin
        if (nxt_seen) begin
          ad_max  <= nxt_max;
          ad_min  <= nxt_min;
          ad_vpp  <= nxt_max - nxt_min;
          ad_freq <= nxt_cnt;
          thresh  <= DW'(mid_sum >> 1);
        end else begin
          // An empty gate publishes zeros and keeps the previous threshold.
          ad_max  <= '0;
          ad_min  <= '0;
          ad_vpp  <= '0;
          ad_freq <= '0;
        end
        run_max <= '0;
        run_min <= D_MAX;
        run_cnt <= '0;
        seen    <= 1'b0;
      end else begin
        run_max <= nxt_max;
        run_min <= nxt_min;
        run_cnt <= nxt_cnt;
        seen    <= nxt_seen;
      end
    end
  end

endmodule
